// File: rtl/gen_share_pkg.sv
// Shared types and helpers for the generator-sharing arbiter: FSM state encoding,
// default data width and index-width helper.
package gen_share_pkg;

    localparam int unsigned DefaultWidth = 32;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StStream,
        StFinish
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gen_share_rr_pick.sv
// Combinational round-robin picker: returns the first pending index at or after i_rr_ptr,
// wrapping modulo N_REQ.
module gen_share_rr_pick
    import gen_share_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    localparam int unsigned IW = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_pending,
    input  logic [IW-1:0]    i_rr_ptr,
    output logic             o_found,
    output logic [IW-1:0]    o_idx
);

    logic [IW:0] w_sum;

    // Scan from the farthest offset down so the nearest pending index is written last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_sum   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_rr_ptr} + (IW + 1)'(k);
            if (w_sum >= (IW + 1)'(N_REQ)) begin
                w_sum = w_sum - (IW + 1)'(N_REQ);
            end
            if (i_pending[w_sum[IW-1:0]]) begin
                o_found = 1'b1;
                o_idx   = w_sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/gen_share_arbiter.sv
// Shares one generator-style instance between N_REQ requesters: queues starts, grants
// round-robin, launches with the winner's arguments and routes the output stream.
module gen_share_arbiter
    import gen_share_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned WIDTH = DefaultWidth,
    localparam int unsigned IW = idx_width(N_REQ)
) (
    input  logic                   _clock,
    input  logic                   _reset,
    input  logic [N_REQ-1:0]       req_start,
    input  logic [N_REQ*WIDTH-1:0] req_base,
    input  logic [N_REQ*WIDTH-1:0] req_limit,
    input  logic [N_REQ*WIDTH-1:0] req_step,
    input  logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ*WIDTH-1:0] req_0,
    output logic [N_REQ-1:0]       req_done,
    output logic                   gen__start,
    output logic                   gen__reset,
    output logic                   gen__ready,
    output logic [WIDTH-1:0]       gen_base,
    output logic [WIDTH-1:0]       gen_limit,
    output logic [WIDTH-1:0]       gen_step,
    input  logic                   gen__valid,
    input  logic                   gen__done,
    input  logic [WIDTH-1:0]       gen__0,
    output logic                   busy,
    output logic [IW-1:0]          grant_id
);

    state_e                       r_state;
    state_e                       w_state_d;
    logic [N_REQ-1:0]             r_pending;
    logic [N_REQ-1:0]             w_clr;
    logic [N_REQ-1:0][WIDTH-1:0]  r_base;
    logic [N_REQ-1:0][WIDTH-1:0]  r_limit;
    logic [N_REQ-1:0][WIDTH-1:0]  r_step;
    logic [IW-1:0]                r_grant;
    logic [IW-1:0]                r_rr_ptr;
    logic [IW-1:0]                w_rr_next;
    logic [IW-1:0]                w_pick_idx;
    logic                         w_pick_found;
    logic                         r_start;
    logic [WIDTH-1:0]             r_gen_base;
    logic [WIDTH-1:0]             r_gen_limit;
    logic [WIDTH-1:0]             r_gen_step;

    gen_share_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .i_pending (r_pending),
        .i_rr_ptr  (r_rr_ptr),
        .o_found   (w_pick_found),
        .o_idx     (w_pick_idx)
    );

    assign w_rr_next = (r_grant == IW'(N_REQ - 1)) ? '0 : r_grant + 1'b1;

    always_comb begin
        w_state_d = r_state;
        w_clr     = '0;
        case (r_state)
            StIdle: begin
                if (w_pick_found) begin
                    w_state_d         = StLaunch;
                    w_clr[w_pick_idx] = 1'b1;
                end
            end
            // gen__done is stale here; the instance only sees its start this cycle.
            StLaunch: w_state_d = StStream;
            // A final beat still held by backpressure keeps us streaming.
            StStream: begin
                if (gen__done && !gen__valid) begin
                    w_state_d = StFinish;
                end
            end
            StFinish: w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    always_comb begin
        gen__ready = 1'b0;
        req_valid  = '0;
        req_0      = '0;
        req_done   = '0;
        if (r_state == StStream) begin
            gen__ready = req_ready[r_grant];
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant == IW'(i)) begin
                req_0[i*WIDTH +: WIDTH] = gen__0;
                req_valid[i]            = (r_state == StStream) && gen__valid;
                req_done[i]             = (r_state == StFinish);
            end
        end
    end

    always_ff @(posedge _clock) begin
        if (_reset) begin
            r_state     <= StIdle;
            r_pending   <= '0;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_start     <= 1'b0;
            r_gen_base  <= '0;
            r_gen_limit <= '0;
            r_gen_step  <= '0;
            r_base      <= '0;
            r_limit     <= '0;
            r_step      <= '0;
        end else begin
            r_state   <= w_state_d;
            // OR-ing starts after the clear keeps a same-cycle restart pending.
            r_pending <= (r_pending & ~w_clr) | req_start;
            r_start   <= (w_state_d == StLaunch);
            for (int i = 0; i < N_REQ; i++) begin
                if (req_start[i]) begin
                    r_base[i]  <= req_base[i*WIDTH +: WIDTH];
                    r_limit[i] <= req_limit[i*WIDTH +: WIDTH];
                    r_step[i]  <= req_step[i*WIDTH +: WIDTH];
                end
            end
            if (r_state == StIdle && w_pick_found) begin
                r_grant     <= w_pick_idx;
                r_gen_base  <= r_base[w_pick_idx];
                r_gen_limit <= r_limit[w_pick_idx];
                r_gen_step  <= r_step[w_pick_idx];
            end
            if (r_state == StFinish) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    assign gen__start = r_start;
    assign gen__reset = _reset;
    assign gen_base   = r_gen_base;
    assign gen_limit  = r_gen_limit;
    assign gen_step   = r_gen_step;
    assign busy       = (r_state != StIdle);
    assign grant_id   = r_grant;

endmodule

// File: tb/tb_gen_share_arbiter.sv
// Self-checking bench for gen_share_arbiter with a behavioural hrange-style generator
// attached to the shared port.
module tb_gen_share_arbiter;

    localparam int N = 2;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_start, req_ready, req_valid, req_done;
    logic [N*W-1:0] req_base, req_limit, req_step, req_0;
    logic           g_start, g_reset, g_ready, g_valid, g_done;
    logic [W-1:0]   gb, gl, gs, g0;
    logic           busy;
    logic [0:0]     grant_id;

    always #5 clk = ~clk;

    gen_share_arbiter #(
        .N_REQ (N),
        .WIDTH (W)
    ) dut (
        ._clock     (clk),
        ._reset     (rst),
        .req_start  (req_start),
        .req_base   (req_base),
        .req_limit  (req_limit),
        .req_step   (req_step),
        .req_ready  (req_ready),
        .req_valid  (req_valid),
        .req_0      (req_0),
        .req_done   (req_done),
        .gen__start (g_start),
        .gen__reset (g_reset),
        .gen__ready (g_ready),
        .gen_base   (gb),
        .gen_limit  (gl),
        .gen_step   (gs),
        .gen__valid (g_valid),
        .gen__done  (g_done),
        .gen__0     (g0),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    // hrange(base, limit, step): emits base, base+step, ... while value < limit.
    logic signed [W-1:0] m_cur, m_lim, m_stp;
    logic                m_run;
    always @(posedge clk) begin
        if (g_reset) begin
            m_run <= 1'b0;
        end else if (g_start) begin
            m_cur <= gb;
            m_lim <= gl;
            m_stp <= gs;
            m_run <= 1'b1;
        end else if (g_valid && g_ready) begin
            m_cur <= m_cur + m_stp;
        end
    end
    assign g_valid = (m_run === 1'b1) && (m_cur < m_lim);
    assign g_done  = !g_valid;
    assign g0      = m_cur;

    int q0[$], q1[$], grants[$], exp_q[$];
    int done0 = 0, done1 = 0, extra_valid = 0, ready_mis = 0;
    int n_checks = 0, n_errors = 0;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (req_valid[0] && req_ready[0]) q0.push_back(int'(req_0[W-1:0]));
            if (req_valid[1] && req_ready[1]) q1.push_back(int'(req_0[2*W-1:W]));
            if (req_done[0]) done0++;
            if (req_done[1]) done1++;
            if (g_start) grants.push_back(int'(grant_id));
            if (req_valid[0] && grant_id != 1'b0) extra_valid++;
            if (req_valid[1] && grant_id != 1'b1) extra_valid++;
            if ((|req_valid) && (g_ready !== req_ready[grant_id])) ready_mis++;
        end
    end

    typedef struct {
        int rid;
        int base;
        int limit;
        int step;
        int n;
        int sum;
        int last;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int dcnt(input int rid);
        return (rid == 0) ? done0 : done1;
    endfunction

    task automatic set_args(input int rid, input int b, input int l, input int s);
        req_start[rid]         = 1'b1;
        req_base[rid*W +: W]   = b;
        req_limit[rid*W +: W]  = l;
        req_step[rid*W +: W]   = s;
    endtask

    task automatic pulse();
        tick();
        req_start = '0;
    endtask

    task automatic wait_done(input int rid, input int target, input int budget, input string name);
        int k;
        k = 0;
        while (dcnt(rid) < target && k < budget) begin
            tick();
            k++;
        end
        chk(name, dcnt(rid), target);
    endtask

    task automatic chk_q(input string name, input int rid);
        int got[$];
        if (rid == 0) got = q0;
        else          got = q1;
        chk({name, "_len"}, got.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            chk($sformatf("%s_%0d", name, k), (k < got.size()) ? got[k] : 32'h7fff_ffff,
                exp_q[k]);
        end
    endtask

    task automatic clear_logs();
        q0.delete();
        q1.delete();
        grants.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, d1, n, sum, last;
        int got[$];

        vecs[0] = '{rid: 0, base: 0,   limit: 10, step: 2, n: 5, sum: 20,  last: 8};
        vecs[1] = '{rid: 1, base: 10,  limit: 12, step: 1, n: 2, sum: 21,  last: 11};
        vecs[2] = '{rid: 1, base: 5,   limit: 5,  step: 1, n: 0, sum: 0,   last: 0};
        vecs[3] = '{rid: 0, base: -3,  limit: 3,  step: 2, n: 3, sum: -3,  last: 1};
        vecs[4] = '{rid: 1, base: 0,   limit: 7,  step: 3, n: 3, sum: 9,   last: 6};
        vecs[5] = '{rid: 1, base: -10, limit: -4, step: 3, n: 2, sum: -17, last: -7};
        vecs[6] = '{rid: 0, base: 7,   limit: 3,  step: 1, n: 0, sum: 0,   last: 0};

        rst = 1'b1;
        req_start = '0;
        req_ready = '0;
        req_base = '0;
        req_limit = '0;
        req_step = '0;
        repeat (2) tick();
        chk("reset_gen_reset", int'(g_reset), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_gen_start", int'(g_start), 0);
        chk("reset_grant", int'(grant_id), 0);
        chk("reset_valid", int'(req_valid), 0);
        chk("reset_done", int'(req_done), 0);
        chk("reset_gen_base", int'(gb), 0);
        rst = 1'b0;
        tick();
        chk("gen_reset_low", int'(g_reset), 0);
        req_ready = '1;

        // Single run hrange(0,10,2) with launch latency checks.
        clear_logs();
        set_args(0, 0, 10, 2);
        pulse();
        chk("launch_not_yet", int'(g_start), 0);
        tick();
        chk("launch_start", int'(g_start), 1);
        chk("launch_base", int'(gb), 0);
        chk("launch_limit", int'(gl), 10);
        chk("launch_step", int'(gs), 2);
        chk("launch_grant", int'(grant_id), 0);
        tick();
        chk("start_one_cycle", int'(g_start), 0);
        wait_done(0, 1, 60, "a_done");
        exp_q = '{0, 2, 4, 6, 8};
        chk_q("a_seq", 0);
        chk("a_req1_silent", q1.size(), 0);
        repeat (3) tick();
        chk("a_done_once", done0, 1);

        for (int v = 0; v < 7; v++) begin
            clear_logs();
            d0 = dcnt(vecs[v].rid);
            set_args(vecs[v].rid, vecs[v].base, vecs[v].limit, vecs[v].step);
            pulse();
            wait_done(vecs[v].rid, d0 + 1, 80, $sformatf("vec%0d_done", v));
            if (vecs[v].rid == 0) got = q0;
            else                  got = q1;
            n = got.size();
            sum = 0;
            foreach (got[k]) sum += got[k];
            last = (n > 0) ? got[n-1] : 0;
            chk($sformatf("vec%0d_n", v), n, vecs[v].n);
            chk($sformatf("vec%0d_sum", v), sum, vecs[v].sum);
            chk($sformatf("vec%0d_last", v), last, vecs[v].last);
            chk($sformatf("vec%0d_other_silent", v), (vecs[v].rid == 0) ? q1.size() : q0.size(), 0);
        end

        // Last table run was requester 0, so the pointer now favours requester 1.
        clear_logs();
        d0 = done0;
        d1 = done1;
        set_args(0, 0, 4, 1);
        set_args(1, 10, 12, 1);
        pulse();
        wait_done(0, d0 + 1, 100, "pair1_done0");
        wait_done(1, d1 + 1, 100, "pair1_done1");
        chk("pair1_grants", grants.size(), 2);
        chk("pair1_grant_first", (grants.size() > 0) ? grants[0] : -1, 1);
        chk("pair1_grant_second", (grants.size() > 1) ? grants[1] : -1, 0);
        exp_q = '{0, 1, 2, 3};
        chk_q("pair1_r0", 0);
        exp_q = '{10, 11};
        chk_q("pair1_r1", 1);

        // Backpressure: ready pattern 1,0,0,1 on requester 0.
        clear_logs();
        d0 = done0;
        set_args(0, 0, 6, 1);
        pulse();
        for (int k = 0; k < 80 && done0 < d0 + 1; k++) begin
            req_ready[0] = (k % 4 == 0 || k % 4 == 3);
            tick();
        end
        req_ready = '1;
        chk("bp_done", done0, d0 + 1);
        exp_q = '{0, 1, 2, 3, 4, 5};
        chk_q("bp_seq", 0);

        // Empty range completes within 8 cycles of the start.
        clear_logs();
        d1 = done1;
        set_args(1, 5, 5, 1);
        pulse();
        wait_done(1, d1 + 1, 7, "empty_done_fast");
        chk("empty_no_valid", q1.size(), 0);

        // Reset mid-STREAM aborts the run; a start during reset is dropped.
        clear_logs();
        set_args(0, 0, 100, 1);
        pulse();
        repeat (5) tick();
        chk("pre_reset_busy", int'(busy), 1);
        d0 = done0;
        rst = 1'b1;
        set_args(1, 40, 42, 1);
        #1;
        chk("midrun_gen_reset", int'(g_reset), 1);
        tick();
        rst = 1'b0;
        req_start = '0;
        #1;
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_valid", int'(req_valid), 0);
        chk("post_reset_done", int'(req_done), 0);
        repeat (4) tick();
        chk("pending_cleared", int'(busy), 0);
        chk("no_done_on_abort", done0, d0);

        // After reset the pointer is 0 again: pair grants 0 then 1.
        clear_logs();
        d0 = done0;
        d1 = done1;
        set_args(0, 0, 4, 1);
        set_args(1, 10, 12, 1);
        pulse();
        wait_done(0, d0 + 1, 100, "pair2_done0");
        wait_done(1, d1 + 1, 100, "pair2_done1");
        chk("pair2_grant_first", (grants.size() > 0) ? grants[0] : -1, 0);
        chk("pair2_grant_second", (grants.size() > 1) ? grants[1] : -1, 1);
        exp_q = '{0, 1, 2, 3};
        chk_q("pair2_r0", 0);
        exp_q = '{10, 11};
        chk_q("pair2_r1", 1);

        // Requester 0 restarts during its own run while requester 1 waits.
        clear_logs();
        d0 = done0;
        d1 = done1;
        set_args(0, 0, 4, 1);
        pulse();
        set_args(1, 30, 32, 1);
        pulse();
        tick();
        chk("restart_during_run", int'(busy), 1);
        set_args(0, 20, 22, 1);
        pulse();
        wait_done(0, d0 + 2, 200, "restart_done0");
        wait_done(1, d1 + 1, 200, "restart_done1");
        chk("restart_grants", grants.size(), 3);
        chk("restart_grant0", (grants.size() > 0) ? grants[0] : -1, 0);
        chk("restart_grant1", (grants.size() > 1) ? grants[1] : -1, 1);
        chk("restart_grant2", (grants.size() > 2) ? grants[2] : -1, 0);
        exp_q = '{0, 1, 2, 3, 20, 21};
        chk_q("restart_r0", 0);
        exp_q = '{30, 31};
        chk_q("restart_r1", 1);

        chk("valid_only_granted", extra_valid, 0);
        chk("gen_ready_mirrors", ready_mis, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gen_share_arbiter.md
Name: gen_share_arbiter

Overview:
- Shares one generator-style module instance (e.g. hrange, with _start/_ready/_valid/_done/_0 and base/limit/step inputs) between N_REQ requesters.
- Each requester sees a generator-like port set. The arbiter queues start requests, grants the instance round-robin, launches it with the winner's arguments, routes the output stream with ready/valid, and signals completion.
- Sits between caller FSMs in generated designs and a single shared callee instance.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- WIDTH, 32, signed width of arguments and output value

Ports:
- _clock  in  1  clock; all logic on rising edge
- _reset  in  1  synchronous, active-high reset
- req_start  in  N_REQ  per-requester start pulse; args are captured in the same cycle
- req_base  in  N_REQ*WIDTH  packed signed base argument, slice i belongs to requester i
- req_limit  in  N_REQ*WIDTH  packed signed limit argument
- req_step  in  N_REQ*WIDTH  packed signed step argument
- req_ready  in  N_REQ  requester ready for output
- req_valid  out  N_REQ  output valid for requester (only the granted bit can be 1)
- req_0  out  N_REQ*WIDTH  output value per requester (granted slice = gen__0, others 0)
- req_done  out  N_REQ  one-cycle pulse when that requester's run completes
- gen__start  out  1  start to shared instance (registered)
- gen__reset  out  1  reset to shared instance
- gen__ready  out  1  ready to shared instance
- gen_base, gen_limit, gen_step  out  WIDTH each  registered arguments to shared instance
- gen__valid  in  1  shared instance output valid
- gen__done  in  1  shared instance done (level; high while idle)
- gen__0  in  WIDTH  shared instance output
- busy  out  1  state != IDLE
- grant_id  out  $clog2(N_REQ)  index of the current grant

Behaviour:
- Reset (sync, active-high): state=IDLE, pending=0, rr_ptr=0, all registered outputs 0, grant_id=0. gen__reset=1 while _reset is high (combinational). Reset mid-run aborts the run with no req_done pulse.
- Pending capture: req_start[i]=1 sets pending[i] and stores args_i at the next edge.
  - A start for an already-pending requester overwrites its args (latest wins).
  - A start from the granted requester during a run queues a new run; it never restarts the current run.
- FSM states IDLE, LAUNCH, STREAM, FINISH.
- IDLE: if pending!=0, the round-robin picker selects the first pending index at or after rr_ptr. The arbiter then registers grant_id, loads gen_base/limit/step from the winner's stored args, clears that pending bit (unless a new start arrives the same cycle), and moves to LAUNCH. Otherwise it stays in IDLE.
- LAUNCH (exactly 1 cycle): gen__start=1, gen__ready=0, gen__done ignored (stale), then STREAM.
- STREAM: gen__start=0.
  - Routing is combinational: gen__ready=req_ready[grant_id]; req_valid[grant_id]=gen__valid; req_0 slice=gen__0.
  - gen__done=1 with gen__valid=0 moves to FINISH.
  - gen__done=1 with gen__valid=1 stays in STREAM until that beat is transferred.
- FINISH (1 cycle): req_done[grant_id]=1, rr_ptr=grant_id+1 mod N_REQ, then IDLE.
- Outside STREAM: gen__ready=0 and req_valid=0.
- Minimum overhead: 3 cycles from a start pulse on an idle arbiter to gen__start high (capture, IDLE pick, LAUNCH); 2 idle cycles (FINISH, IDLE) between back-to-back runs.
- No data reordering or buffering; values pass with zero added latency. Backpressure from the requester holds the generator.
- Empty range (base>=limit): no valid beats, req_done pulses normally.
- Simultaneous events: start and grant for the same requester in one cycle leave that pending bit set with the new args. A start arriving while _reset is high is dropped.

Decomposition:
- Package gen_share_pkg holds the state enum (IDLE, LAUNCH, STREAM, FINISH), the default WIDTH, and the index-width function.
- One sub-module, gen_share_rr_pick: combinational round-robin picker with inputs pending[N_REQ] and rr_ptr, outputs found and idx.
- The arbiter top holds the FSM, argument storage and routing.

Test Plan:
- Requester 0 starts hrange(0,10,2), req_ready=1 -> req_0[0] streams 0,2,4,6,8, each with req_valid[0]; then req_done[0] pulses once; req_valid[1] is never 1.
- Requesters 0 (0,4,1) and 1 (10,12,1) start in the same cycle -> req0 gets 0,1,2,3 and its done; req1 then gets 10,11 and its done; grant order 0 then 1; next simultaneous pair grants 1 first.
- Backpressure: req_ready[0] toggles 1,0,0,1 with hrange(0,6,1) -> gen__ready mirrors it, no value lost or duplicated, sequence 0..5.
- Empty range (5,5,1) for requester 1 -> no req_valid; req_done[1] pulses within 8 cycles of the start.
- _reset held high for 1 cycle mid-STREAM -> gen__reset=1 that cycle; next cycle busy=0, all req_valid and req_done 0, pending cleared; a later start runs normally.
- Requester 0 re-starts with (20,22,1) during its own run while requester 1 is pending -> current run completes, requester 1 is served, then requester 0 gets 20,21.
